host_mem_responder: RTL
=======================

HOST_MEM_RESPONDER -- requirements
Module: host_mem_responder

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 4096: 32-bit words of backing store, power of two.
REQ-002 SHALL have parameter LATENCY, default 2: grant-to-rvalid delay in cycles, legal range 1..8.
REQ-003 SHALL have parameter GNT_DELAY, default 0: cycles a request is held before grant, legal range 0..7.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_i, input, 1 bit: OBI request valid.
REQ-007 SHALL have port gnt_o, output, 1 bit: OBI grant.
REQ-008 SHALL have port addr_i, input, 32 bits: byte address; bits [1:0] ignored.
REQ-009 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port be_i, input, 4 bits: byte enables, bit n selects byte lane n.
REQ-011 SHALL have port wdata_i, input, 32 bits: write data.
REQ-012 SHALL have port rvalid_o, output, 1 bit: response valid, exactly one per granted request.
REQ-013 SHALL have port rdata_o, output, 32 bits: read data; 0 for write responses.
REQ-014 SHALL have port err_o, output, 1 bit: qualifies rvalid_o; 1 = address out of range.

Function
REQ-015 SHALL treat a request as accepted ("handshake") in any cycle where req_i and gnt_o are both 1 at the rising clk_i edge.
REQ-016 SHALL implement the grant FSM with states IDLE, WAIT and GRANT.
- IDLE -> WAIT on req_i when GNT_DELAY>0.
- WAIT counts GNT_DELAY cycles, then -> GRANT.
- GRANT asserts gnt_o combinationally while req_i is 1, then returns to IDLE.
REQ-017 SHALL, when GNT_DELAY=0, drive gnt_o = req_i combinationally, so back-to-back handshakes occur every cycle.
REQ-018 SHALL return the FSM to IDLE and restart the count if req_i drops in WAIT; OBI forbids this, but the block SHALL tolerate it.
REQ-019 SHALL compute word index = addr_i[log2(NUM_WORDS)+1:2], with the address in range iff addr_i[31:2] < NUM_WORDS.
REQ-020 SHALL, at the handshake edge of an in-range write, update only the byte lanes enabled by be_i; be_i=0 changes nothing but still produces a response.
REQ-021 SHALL, at the handshake edge of an in-range read, sample the word; a write on the previous handshake to the same word SHALL be visible.
REQ-022 SHALL drop out-of-range writes; out-of-range reads SHALL return rdata_o=32'hBADCAB1E; both SHALL respond with err_o=1.
REQ-023 SHALL carry each handshake through a LATENCY-stage shift pipeline holding {valid, err, data}, so rvalid_o is asserted exactly LATENCY cycles after the handshake edge.
REQ-024 SHALL return responses in order, and SHALL NOT stall or drop them, since OBI has no response backpressure.
REQ-025 SHALL hold rdata_o and err_o at 0 whenever rvalid_o is 0.
REQ-026 SHALL have no outstanding-request limit other than LATENCY; at most LATENCY transactions are in flight.

Reset
REQ-027 SHALL, while rst_i is 1, hold the FSM in IDLE, clear all pipeline valid bits, and drive rvalid_o=0, err_o=0, rdata_o=0 and gnt_o=0.
REQ-028 SHALL discard transactions in flight when reset asserts, producing no responses for them after release.
REQ-029 SHALL NOT reset memory contents.

Structure
REQ-030 SHALL place the following in the shared e_gpu package: OBI width constants (address 32, data 32, be 4), the error pattern 32'hBADCAB1E, and a grant-FSM state enum typedef.
REQ-031 SHALL instantiate one sub-module, resp_delay_line (parameter LATENCY, payload {err, data}), for the response pipeline.
REQ-032 SHALL be usable as the host-side memory model attached to the GPU's host memory OBI master.

Verification
REQ-033 SHALL cover: with LATENCY=2 and GNT_DELAY=0, write 0x11223344 to 0x40 with be=4'hF, then read 0x40 on the next cycle -> gnt_o in both cycles; rvalid at +2 and +3; second rdata_o=0x11223344, err_o=0.
REQ-034 SHALL cover: write 0xAABBCCDD to 0x80 with be=4'b0101 over an existing 0x00000000 -> a subsequent read returns 0x00BB00DD.
REQ-035 SHALL cover: with GNT_DELAY=3 and req_i held -> gnt_o first high in the 4th cycle after req_i rises; exactly one response.
REQ-036 SHALL cover: with NUM_WORDS=4096, read 0x0000_4000 -> rvalid with err_o=1 and rdata_o=0xBADCAB1E; a write to the same address leaves memory unchanged.
REQ-037 SHALL cover: 8 back-to-back reads with LATENCY=4 -> 8 consecutive rvalid cycles starting 4 cycles after the first handshake, data in request order.
REQ-038 SHALL cover: rst_i asserted with 2 reads in flight -> outputs go to 0 asynchronously; no rvalid after release until a new handshake.

Source files
------------

// File: rtl/e_gpu_pkg.sv
// Shared OBI definitions for the GPU host-side memory model.
// Holds bus widths, the out-of-range read pattern and the grant FSM state type.
package e_gpu_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = 4;

    localparam logic [OBI_DATA_W-1:0] OBI_ERR_DATA = 32'hBADCAB1E;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_WAIT,
        GNT_GRANT
    } gnt_state_e;

    // Replace only the byte lanes selected by be; other lanes keep old_word.
    function automatic logic [OBI_DATA_W-1:0] merge_bytes(
        input logic [OBI_DATA_W-1:0] old_word,
        input logic [OBI_DATA_W-1:0] new_word,
        input logic [OBI_BE_W-1:0]   be
    );
        logic [OBI_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < OBI_BE_W; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/host_mem_responder_if.sv
// OBI request/response bundle between the GPU host master and the memory model.
interface host_mem_responder_if;
    import e_gpu_pkg::*;

    logic                  req_i;
    logic                  gnt_o;
    logic [OBI_ADDR_W-1:0] addr_i;
    logic                  we_i;
    logic [OBI_BE_W-1:0]   be_i;
    logic [OBI_DATA_W-1:0] wdata_i;
    logic                  rvalid_o;
    logic [OBI_DATA_W-1:0] rdata_o;
    logic                  err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/resp_delay_line.sv
// Fixed-length response pipeline: every accepted request emerges exactly LATENCY cycles later.
// Payload is forced to zero at the output whenever the valid bit is low.
module resp_delay_line #(
    parameter int LATENCY = 2,
    parameter int W       = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         vld_q [LATENCY];
    logic [W-1:0] dat_q [LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[LATENCY-1];
    assign data_o  = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : '0;

endmodule

// File: rtl/host_mem_responder.sv
// Host-side OBI memory model: byte-enabled word store, programmable grant delay and
// fixed-latency in-order responses.
//
// state     | meaning
// GNT_IDLE  | no request pending; gnt follows req directly when GNT_DELAY is 0
// GNT_WAIT  | request held, down-counting the grant delay
// GNT_GRANT | gnt driven from req for one cycle, then back to idle
module host_mem_responder
    import e_gpu_pkg::*;
#(
    parameter int NUM_WORDS = 4096,
    parameter int LATENCY   = 2,
    parameter int GNT_DELAY = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    host_mem_responder_if.slave  bus
);

    localparam int              IDX_W      = $clog2(NUM_WORDS);
    localparam logic [2:0]      CNT_LOAD   = (GNT_DELAY > 0) ? 3'(GNT_DELAY - 1) : 3'd0;
    localparam logic [30:0]     WORD_LIMIT = 31'(NUM_WORDS);

    gnt_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       gnt_raw;
    logic       gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= GNT_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_raw = 1'b0;
        if (GNT_DELAY == 0) begin
            gnt_raw = bus.req_i;
        end else begin
            case (state_q)
                GNT_IDLE: begin
                    if (bus.req_i) begin
                        state_d = GNT_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
                GNT_WAIT: begin
                    // A master that withdraws mid-wait starts over from idle.
                    if (!bus.req_i)        state_d = GNT_IDLE;
                    else if (cnt_q == 3'd0) state_d = GNT_GRANT;
                    else                   cnt_d   = cnt_q - 3'd1;
                end
                GNT_GRANT: begin
                    gnt_raw = bus.req_i;
                    state_d = GNT_IDLE;
                end
                default: state_d = GNT_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_raw & ~rst_i;
    assign bus.gnt_o = gnt;

    logic                  hs;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [OBI_DATA_W-1:0] mem [NUM_WORDS];
    logic [OBI_DATA_W-1:0] rsp_data;
    logic                  rsp_err;
    logic [OBI_DATA_W:0]   rsp_in;
    logic [OBI_DATA_W:0]   rsp_out;

    assign hs       = bus.req_i & gnt;
    assign in_range = {1'b0, bus.addr_i[31:2]} < WORD_LIMIT;
    assign idx      = bus.addr_i[IDX_W+1:2];

    // Backing store is deliberately not reset so contents survive a bus reset.
    always_ff @(posedge clk_i) begin
        if (hs && bus.we_i && in_range) begin
            mem[idx] <= merge_bytes(mem[idx], bus.wdata_i, bus.be_i);
        end
    end

    always_comb begin
        rsp_err  = ~in_range;
        rsp_data = '0;
        if (!bus.we_i) rsp_data = in_range ? mem[idx] : OBI_ERR_DATA;
        rsp_in   = hs ? {rsp_err, rsp_data} : '0;
    end

    resp_delay_line #(
        .LATENCY (LATENCY),
        .W       (OBI_DATA_W + 1)
    ) u_resp_delay_line (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (hs),
        .data_i  (rsp_in),
        .valid_o (bus.rvalid_o),
        .data_o  (rsp_out)
    );

    assign bus.err_o   = rsp_out[OBI_DATA_W];
    assign bus.rdata_o = rsp_out[OBI_DATA_W-1:0];

endmodule
